// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline constants: register-file geometry, hazard latencies and
// the stall-counter width used by the decode-stage scoreboard.
package reg_scoreboard_pkg;

   localparam int PKG_NREG     = 4;
   localparam int PKG_RW       = 2;
   localparam int PKG_CW       = 2;
   localparam int PKG_LOAD_LAT = 1;
   localparam int PKG_ALU_LAT  = 0;

   localparam int STALL_CNT_W  = 16;

   typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-stage issue bus between the decoder (master) and the scoreboard (slave).
interface reg_scoreboard_if
   import reg_scoreboard_pkg::*;
#(
   parameter int RW   = PKG_RW,
   parameter int NREG = PKG_NREG
);
   logic            issue_valid;
   logic [RW-1:0]   src1;
   logic [RW-1:0]   src2;
   logic            src1_en;
   logic            src2_en;
   logic [RW-1:0]   dest;
   logic            dest_en;
   logic            is_load;
   logic            flush;
   logic            stall;
   logic            issue_fire;
   logic [NREG-1:0] busy;
   stall_cnt_t      stall_count;

   modport master (
      output issue_valid, src1, src2, src1_en, src2_en, dest, dest_en, is_load, flush,
      input  stall, issue_fire, busy, stall_count
   );

   modport slave (
      input  issue_valid, src1, src2, src1_en, src2_en, dest, dest_en, is_load, flush,
      output stall, issue_fire, busy, stall_count
   );
endinterface

// File: rtl/reg_scoreboard_countdown.sv
// Per-register hazard countdown: clear beats load, load beats decrement.
module reg_countdown #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   output logic          busy_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: stalls issue while a source or destination
// register still has an unforwardable write pending.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NREG     = PKG_NREG,
   parameter int RW       = PKG_RW,
   parameter int LOAD_LAT = PKG_LOAD_LAT,
   parameter int ALU_LAT  = PKG_ALU_LAT,
   parameter int CW       = PKG_CW
) (
   input logic             clk,
   input logic             rst_n,
   reg_scoreboard_if.slave sb
);

   logic [NREG-1:0] busy;
   logic            stall;
   logic            fire;
   logic [CW-1:0]   load_val;
   stall_cnt_t      stall_count_q, stall_count_d;

   // Hazard check uses pre-flush state so a squashed cycle still reports its stall.
   assign stall = sb.issue_valid & ((sb.src1_en & busy[sb.src1]) |
                                    (sb.src2_en & busy[sb.src2]) |
                                    (sb.dest_en & busy[sb.dest]));
   assign fire     = sb.issue_valid & ~stall & ~sb.flush;
   assign load_val = sb.is_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);

   for (genvar r = 0; r < NREG; r++) begin : g_reg
      reg_countdown #(.CW(CW)) u_cnt (
         .clk        (clk),
         .rst_n      (rst_n),
         .clear_i    (sb.flush),
         .load_i     (fire & sb.dest_en & (sb.dest == RW'(r))),
         .load_val_i (load_val),
         .busy_o     (busy[r])
      );
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1))
         stall_count_d = stall_count_q + stall_cnt_t'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_count_q <= '0;
      else
         stall_count_q <= stall_count_d;
   end

   assign sb.stall       = stall;
   assign sb.issue_fire  = fire;
   assign sb.busy        = busy;
   assign sb.stall_count = stall_count_q;

endmodule
